// File: rtl/ffs_vec_build_m_if.sv
// Stream bundle for ffs_vec_build_m: index beats in, finished vector out.
// The slave side is the vector builder; the master side is its environment
// (index producer upstream plus result consumer downstream).
interface ffs_vec_build_m_if #(
  parameter int VECTOR_WIDTH = 8
);
  localparam int W         = (VECTOR_WIDTH < 1) ? 1 : VECTOR_WIDTH;
  localparam int IDX_WIDTH = $clog2((W < 2) ? 2 : W);
  localparam int CNT_WIDTH = $clog2(W + 1);

  // index stream
  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_WIDTH-1:0] in_idx;
  logic                 in_last;

  // result stream
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_vec;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_err;

  modport slave (
    input  in_valid,
    input  in_idx,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_vec,
    output out_count,
    output out_err
  );

  modport master (
    output in_valid,
    output in_idx,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_vec,
    input  out_count,
    input  out_err
  );
endinterface

// File: rtl/ffs_vec_build_m.sv
// Rebuilds a bit vector from a stream of bit indices (inverse of an ffs
// encoder). Each accepted index is decoded one-hot and ORed into an
// accumulator; the beat flagged last closes the frame, and the result is
// then held on a valid/ready output until it is taken.
module ffs_vec_build_m #(
  parameter int VECTOR_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  ffs_vec_build_m_if.slave bus
);
  localparam int W         = (VECTOR_WIDTH < 1) ? 1 : VECTOR_WIDTH;
  localparam int IDX_WIDTH = $clog2((W < 2) ? 2 : W);
  localparam int CNT_WIDTH = $clog2(W + 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_reg;
  logic [W-1:0]         acc_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 err_reg;

  logic [W-1:0]         hit;
  logic                 in_range;
  logic                 new_bit;
  logic                 accept;

  // One-hot decode of the incoming index. Indices >= W match no position,
  // which is how out-of-range beats are recognised.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_dec
      assign hit[gi] = (bus.in_idx == IDX_WIDTH'(gi));
    end
  endgenerate

  assign in_range = |hit;
  // The bit is new only if it was not already set, so duplicates count once.
  assign new_bit  = |(hit & ~acc_reg);

  // Handshake flags come straight from the state; reset forces both low so
  // nothing is offered or taken while the block is being cleared.
  assign bus.in_ready  = (state_reg == ACCUM) & ~rst;
  assign bus.out_valid = (state_reg == HOLD)  & ~rst;
  assign accept        = bus.in_valid & bus.in_ready;

  // Result is the accumulator itself; it is frozen while in HOLD.
  assign bus.out_vec   = acc_reg;
  assign bus.out_count = count_reg;
  assign bus.out_err   = err_reg;

  // Frame FSM: accumulate beats until last, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (in_range) begin
              acc_reg <= acc_reg | hit;
              if (new_bit) begin
                count_reg <= count_reg + CNT_WIDTH'(1);
              end
            end else begin
              err_reg <= 1'b1;
            end
            if (bus.in_last) begin
              state_reg <= HOLD;
            end
          end
        end
        HOLD: begin
          // Result taken: start a fresh frame. No beat is accepted this cycle.
          if (bus.out_ready) begin
            acc_reg   <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        default: begin
          state_reg <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ffs_vec_build_m.sv
// Testbench for ffs_vec_build_m: three instances (W=8, W=6, W=1) on one clock.
// Table-driven frames for W=8 plus hand-written multi-cycle sequences.
module tb_ffs_vec_build_m;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ffs_vec_build_m_if #(.VECTOR_WIDTH(8)) if8 ();
  ffs_vec_build_m_if #(.VECTOR_WIDTH(6)) if6 ();
  ffs_vec_build_m_if #(.VECTOR_WIDTH(1)) if1 ();

  ffs_vec_build_m #(.VECTOR_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  ffs_vec_build_m #(.VECTOR_WIDTH(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
  ffs_vec_build_m #(.VECTOR_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    bit         last;
    logic [7:0] vec;
    int         cnt;
    bit         err;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input bit v, input int idx, input bit last);
    case (w)
      8: begin if8.in_valid = v; if8.in_idx = 3'(idx); if8.in_last = last; end
      6: begin if6.in_valid = v; if6.in_idx = 3'(idx); if6.in_last = last; end
      default: begin if1.in_valid = v; if1.in_idx = 1'(idx); if1.in_last = last; end
    endcase
  endtask

  task automatic get(input int w, output logic ir, output logic ov,
                     output logic [31:0] v, output logic [31:0] c, output logic e);
    case (w)
      8: begin
        ir = if8.in_ready; ov = if8.out_valid;
        v = 32'(if8.out_vec); c = 32'(if8.out_count); e = if8.out_err;
      end
      6: begin
        ir = if6.in_ready; ov = if6.out_valid;
        v = 32'(if6.out_vec); c = 32'(if6.out_count); e = if6.out_err;
      end
      default: begin
        ir = if1.in_ready; ov = if1.out_valid;
        v = 32'(if1.out_vec); c = 32'(if1.out_count); e = if1.out_err;
      end
    endcase
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted.
  task automatic beat(input int w, input int idx, input bit last, input string name);
    logic ir, ov, e;
    logic [31:0] v, c;
    int n = 0;
    drive(w, 1'b1, idx, last);
    get(w, ir, ov, v, c, e);
    while (!ir && n < 20) begin
      step();
      n++;
      get(w, ir, ov, v, c, e);
    end
    check({name, " in_ready"}, 32'(ir), 32'd1);
    step();
    drive(w, 1'b0, 0, 1'b0);
  endtask

  task automatic check_out(input int w, input string name, input logic [31:0] ev,
                           input logic [31:0] ec, input logic ee);
    logic ir, ov, e;
    logic [31:0] v, c;
    get(w, ir, ov, v, c, e);
    check({name, " out_valid"}, 32'(ov), 32'd1);
    check({name, " in_ready_low"}, 32'(ir), 32'd0);
    check({name, " out_vec"}, v, ev);
    check({name, " out_count"}, c, ec);
    check({name, " out_err"}, 32'(e), 32'(ee));
  endtask

  task automatic check_idle(input int w, input string name);
    logic ir, ov, e;
    logic [31:0] v, c;
    get(w, ir, ov, v, c, e);
    check({name, " out_valid_low"}, 32'(ov), 32'd0);
    check({name, " in_ready_high"}, 32'(ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic ir, ov, e;
    logic [31:0] v, c;

    // W=8 frame table: multi-beat with duplicate, eight single-beat frames,
    // and a frame with both ends of the vector plus a duplicate.
    tbl[0] = '{3, 1'b0, 8'h00, 0, 1'b0};
    tbl[1] = '{5, 1'b0, 8'h00, 0, 1'b0};
    tbl[2] = '{3, 1'b1, 8'h28, 2, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tbl[3 + i] = '{i, 1'b1, 8'(1 << i), 1, 1'b0};
    end
    tbl[11] = '{7, 1'b0, 8'h00, 0, 1'b0};
    tbl[12] = '{0, 1'b0, 8'h00, 0, 1'b0};
    tbl[13] = '{7, 1'b1, 8'h81, 2, 1'b0};

    rst = 1'b1;
    drive(8, 1'b0, 0, 1'b0);
    drive(6, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 0, 1'b0);
    if8.out_ready = 1'b1;
    if6.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    step();
    step();

    // Reset state
    for (int w = 0; w < 3; w++) begin
      int ww;
      ww = (w == 0) ? 8 : (w == 1) ? 6 : 1;
      get(ww, ir, ov, v, c, e);
      check($sformatf("rst W%0d in_ready", ww), 32'(ir), 32'd0);
      check($sformatf("rst W%0d out_valid", ww), 32'(ov), 32'd0);
    end
    get(8, ir, ov, v, c, e);
    check("rst W8 acc", v, 32'h0);
    check("rst W8 count", c, 32'd0);
    check("rst W8 err", 32'(e), 32'd0);

    rst = 1'b0;
    #1;
    check_idle(8, "post_rst W8");
    check_idle(6, "post_rst W6");
    check_idle(1, "post_rst W1");

    // Table-driven W=8 frames with out_ready=1
    for (int i = 0; i < 14; i++) begin
      beat(8, tbl[i].idx, tbl[i].last, $sformatf("tbl%0d", i));
      if (tbl[i].last) begin
        check_out(8, $sformatf("tbl%0d", i), 32'(tbl[i].vec), 32'(tbl[i].cnt), tbl[i].err);
        step();
        // out_valid lasted one cycle and the next beat can go right away
        check_idle(8, $sformatf("tbl%0d after", i));
      end
    end

    // W=8: result stalled 5 cycles while a beat waits upstream
    if8.out_ready = 1'b0;
    drive(8, 1'b1, 7, 1'b1);
    step();
    drive(8, 1'b1, 2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check_out(8, $sformatf("stall%0d", k), 32'h80, 32'd1, 1'b0);
      step();
    end
    if8.out_ready = 1'b1;
    step();
    check_idle(8, "stall release");
    step();
    check_out(8, "stall next", 32'h04, 32'd1, 1'b0);
    drive(8, 1'b0, 0, 1'b0);
    step();
    check_idle(8, "stall done");

    // W=8: reset in the middle of a frame discards it
    beat(8, 1, 1'b0, "rmid a");
    beat(8, 2, 1'b0, "rmid b");
    rst = 1'b1;
    step();
    get(8, ir, ov, v, c, e);
    check("rmid in_ready", 32'(ir), 32'd0);
    check("rmid out_valid", 32'(ov), 32'd0);
    rst = 1'b0;
    #1;
    check_idle(8, "rmid release");
    beat(8, 4, 1'b1, "rmid c");
    check_out(8, "rmid", 32'h10, 32'd1, 1'b0);
    step();

    // W=8: reset while a result is pending discards it
    if8.out_ready = 1'b0;
    beat(8, 5, 1'b1, "rhold");
    check_out(8, "rhold pend", 32'h20, 32'd1, 1'b0);
    rst = 1'b1;
    step();
    get(8, ir, ov, v, c, e);
    check("rhold out_valid", 32'(ov), 32'd0);
    rst = 1'b0;
    #1;
    check_idle(8, "rhold release");
    get(8, ir, ov, v, c, e);
    check("rhold acc", v, 32'h0);
    check("rhold count", c, 32'd0);
    if8.out_ready = 1'b1;

    // W=6: out-of-range index sets err, next frame is clean
    beat(6, 0, 1'b0, "w6 a");
    beat(6, 7, 1'b1, "w6 b");
    check_out(6, "w6 f1", 32'h01, 32'd1, 1'b1);
    step();
    beat(6, 2, 1'b1, "w6 c");
    check_out(6, "w6 f2", 32'h04, 32'd1, 1'b0);
    step();
    beat(6, 6, 1'b1, "w6 d");
    check_out(6, "w6 f3", 32'h00, 32'd0, 1'b1);
    step();
    beat(6, 5, 1'b0, "w6 e");
    beat(6, 5, 1'b1, "w6 f");
    check_out(6, "w6 f4", 32'h20, 32'd1, 1'b0);
    step();

    // W=1
    beat(1, 0, 1'b1, "w1 a");
    check_out(1, "w1 f1", 32'h1, 32'd1, 1'b0);
    step();
    beat(1, 1, 1'b1, "w1 b");
    check_out(1, "w1 f2", 32'h0, 32'd0, 1'b1);
    step();
    check_idle(1, "w1 done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
